aes_stream_packer: RTL
======================

Name: aes_stream_packer

Overview:
- Upstream/downstream wrapper around the fixed-key 10-round AES cipher pipeline.
- Assembles a valid-qualified byte stream into 128-bit plaintext blocks and drives them onto the cipher's datain.
- Tracks each issued block through the cipher's fixed latency with a valid delay line.
- Registers the matching dataout as a flagged ciphertext word with a running block count.

Parameters:
- PIPE_LAT, 10: cycles from a value on cipher datain to the corresponding value on cipher dataout. The cipher has one register per round.
- CNT_W, 16: width of the ciphertext block counter.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_data, input, 8: plaintext byte.
- in_valid, input, 1: in_data is valid this cycle.
- in_last, input, 1: qualifies in_valid; this byte ends the message and a partial block is flushed.
- in_ready, output, 1: byte accepted when in_valid && in_ready.
- blk_data, output, 128: plaintext to cipher datain. Held stable between issues.
- blk_valid, output, 1: one-cycle pulse; blk_data is a new block this cycle.
- cipher_dout, input, 128: cipher dataout.
- ct_data, output, 128: registered ciphertext.
- ct_valid, output, 1: one-cycle pulse; ct_data is new.
- ct_count, output, CNT_W: number of ct_valid pulses since reset, modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, rst high at a clk edge) applies the following next cycle:
  - in_ready=0, blk_data=0, blk_valid=0, ct_data=0, ct_valid=0, ct_count=0.
  - Byte counter = 0, assembly register = 0, valid delay line = all zeros, FSM in IDLE.
- After reset: in_ready=1 every cycle. The cipher never stalls, and the assembly register is separate from blk_data, so back-to-back bytes are accepted with no bubbles.
- Byte order: the first accepted byte of a block goes to bits [127:120]; byte k goes to [127-8k:120-8k] (FIPS-197 order).
- FSM:
  - IDLE: counter=0, no bytes held. An accepted byte moves to FILL, or issues immediately if in_last.
  - FILL: 1..15 bytes held.
  - Issue happens on the edge that accepts the 16th byte, or any byte with in_last.
  - On issue:
    - blk_data <= assembled word; unfilled positions are forced to 0 (zero padding).
    - blk_valid=1 for exactly the next cycle.
    - Counter <= 0, assembly register <= 0, state <= IDLE.
- in_last on the 16th byte issues exactly one block, never an extra padding block.
- in_last with in_valid=0 is ignored.
- Consecutive issues can be as close as 16 cycles apart (or 1 cycle for single-byte in_last messages). blk_valid may therefore pulse on consecutive cycles.
- Valid delay line: PIPE_LAT-bit shift register, input blk_valid, shifted every cycle.
- Ciphertext capture: when delay-line tap PIPE_LAT-1 is 1, then on the next edge:
  - ct_data <= cipher_dout;
  - ct_valid pulses for one cycle;
  - ct_count increments, wrapping at 2^CNT_W.
- Latency: blk_valid high in cycle T means ct_valid is high in cycle T+PIPE_LAT+1. The pulse holds the cipher output of cycle T+PIPE_LAT.
- ct_data holds its value between pulses.
- Reset mid-operation: partial bytes are dropped and in-flight blocks are never flagged, because the delay line is cleared. The cipher pipeline itself is not reset; its stale data is simply unflagged.

Decomposition:
- Shared package aes_pkg:
  - AES_BLK_W=128, AES_BYTES=16, AES_PIPE_LAT=10;
  - FSM state enum {IDLE, FILL};
  - FIPS-197 test vectors for benches.
- One natural sub-module: aes_valid_delay, a parameterised 1-bit shift register of depth PIPE_LAT with synchronous reset. It is reusable for any fixed-latency stage in the cipher path.
- The cipher itself is instantiated by the parent, not inside this block.

Test Plan:
- FIPS-197 vector. Stream bytes 00 11 22 … ff back-to-back, cipher attached.
  - blk_data=00112233445566778899aabbccddeeff with blk_valid on the cycle after the 16th byte.
  - 11 cycles later ct_valid=1, ct_data=69c4e0d86a7b0430d8cdb78070b4c55a, ct_count=1.
- Partial flush. Send 3 bytes aa bb cc, with in_last on cc.
  - blk_data=aabbcc00000000000000000000000000, one blk_valid pulse, state returns to IDLE, next byte lands in [127:120].
- Exact-multiple last. 16 bytes with in_last on the 16th → exactly one blk_valid; no second pulse follows.
- Throughput. Stream 48 bytes continuously with in_ready held 1.
  - 3 blk_valid pulses 16 cycles apart.
  - 3 ct_valid pulses 16 cycles apart, ct_count 1→2→3, each ct_data matching the reference model.
- Reset mid-flight. Assert rst for 1 cycle 5 cycles after blk_valid, while a second block is half-filled.
  - No ct_valid ever appears for either block.
  - ct_count=0.
  - The next full 16-byte block encrypts correctly.
- Counter wrap. Force or preload ct_count=ffff with CNT_W=16, issue 1 block → ct_count=0000 with ct_valid=1.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES block constants, packer FSM states and FIPS-197 vectors
package aes_pkg;

  localparam int AES_BLK_W    = 128;
  localparam int AES_BYTES    = 16;
  localparam int AES_PIPE_LAT = 10;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pack_state_e;

  // FIPS-197 appendix C.1 (AES-128)
  localparam logic [AES_BLK_W-1:0] AES_FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [AES_BLK_W-1:0] AES_FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [AES_BLK_W-1:0] AES_FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_stream_packer_if.sv
// rtl/aes_stream_packer_if.sv - byte stream in, cipher block out/in, flagged ciphertext out
interface aes_stream_packer_if #(
  parameter int CNT_W = 16
);
  import aes_pkg::*;

  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [AES_BLK_W-1:0] blk_data;
  logic                 blk_valid;
  logic [AES_BLK_W-1:0] cipher_dout;
  logic [AES_BLK_W-1:0] ct_data;
  logic                 ct_valid;
  logic [CNT_W-1:0]     ct_count;

  modport master (
    output in_data, in_valid, in_last, cipher_dout,
    input  in_ready, blk_data, blk_valid, ct_data, ct_valid, ct_count
  );

  modport slave (
    input  in_data, in_valid, in_last, cipher_dout,
    output in_ready, blk_data, blk_valid, ct_data, ct_valid, ct_count
  );

endinterface

// File: rtl/aes_valid_delay.sv
// rtl/aes_valid_delay.sv - 1-bit valid shift register matching a fixed-latency datapath
module aes_valid_delay #(
  parameter int DEPTH = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= (sr_q << 1) | DEPTH'(din);
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/aes_stream_packer.sv
// rtl/aes_stream_packer.sv - packs bytes into AES blocks for the cipher pipeline and
// flags the matching ciphertext once the pipeline latency has elapsed
module aes_stream_packer
  import aes_pkg::*;
#(
  parameter int PIPE_LAT = AES_PIPE_LAT,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  aes_stream_packer_if.slave bus
);

  localparam int BYTE_CNT_W = $clog2(AES_BYTES);

  pack_state_e           state_q, state_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [AES_BLK_W-1:0]  asm_q, asm_d, merged;
  logic [AES_BLK_W-1:0]  blk_data_q, blk_data_d;
  logic                  blk_valid_q, blk_valid_d;
  logic                  in_ready_q;
  logic                  accept, issue;
  logic                  ct_flag;
  logic [AES_BLK_W-1:0]  ct_data_q;
  logic                  ct_valid_q;
  logic [CNT_W-1:0]      ct_count_q;

  assign accept = bus.in_valid && in_ready_q;
  assign issue  = accept && (bus.in_last || byte_cnt_q == BYTE_CNT_W'(AES_BYTES - 1));

  // Unfilled lanes of asm_q are always zero, so OR-ing in the new byte also zero-pads
  assign merged = asm_q | ({bus.in_data, {(AES_BLK_W-8){1'b0}}} >> {byte_cnt_q, 3'b000});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      blk_data_q  <= '0;
      blk_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      blk_data_q  <= blk_data_d;
      blk_valid_q <= blk_valid_d;
      in_ready_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    blk_data_d  = blk_data_q;
    blk_valid_d = 1'b0;

    case (state_q)
      IDLE:    if (accept) state_d = FILL;
      FILL:    state_d = FILL;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      asm_d      = merged;
      byte_cnt_d = byte_cnt_q + 1'b1;
    end

    // Issue takes priority: a 16th byte or any in_last byte closes the block
    if (issue) begin
      blk_data_d  = merged;
      blk_valid_d = 1'b1;
      asm_d       = '0;
      byte_cnt_d  = '0;
      state_d     = IDLE;
    end
  end

  aes_valid_delay #(
    .DEPTH(PIPE_LAT)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (blk_valid_q),
    .dout (ct_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ct_data_q  <= '0;
      ct_valid_q <= 1'b0;
      ct_count_q <= '0;
    end else begin
      ct_valid_q <= ct_flag;
      if (ct_flag) begin
        ct_data_q  <= bus.cipher_dout;
        ct_count_q <= ct_count_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.blk_data  = blk_data_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.ct_data   = ct_data_q;
  assign bus.ct_valid  = ct_valid_q;
  assign bus.ct_count  = ct_count_q;

endmodule
